// File: rtl/mdu_pkg.sv
// Shared definitions for the E-stage multiply/divide unit: opcode encoding,
// data width, default latencies and opcode classification helpers.
package mdu_pkg;

    localparam int DATA_W          = 32;
    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    localparam logic [3:0] MDU_NONE  = 4'd0;
    localparam logic [3:0] MDU_MULT  = 4'd1;
    localparam logic [3:0] MDU_MULTU = 4'd2;
    localparam logic [3:0] MDU_DIV   = 4'd3;
    localparam logic [3:0] MDU_DIVU  = 4'd4;
    localparam logic [3:0] MDU_MFHI  = 4'd5;
    localparam logic [3:0] MDU_MFLO  = 4'd6;
    localparam logic [3:0] MDU_MTHI  = 4'd7;
    localparam logic [3:0] MDU_MTLO  = 4'd8;

    // Ops that launch a multi-cycle operation.
    function automatic logic is_start_op(input logic [3:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU) ||
               (op == MDU_DIV)  || (op == MDU_DIVU);
    endfunction

    // Divide-class ops (select the divide latency and divide result).
    function automatic logic is_div_op(input logic [3:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational HI/LO result calculator for mult/multu/div/divu.
// Signed divide works on magnitudes and restores signs afterwards, which also
// yields 0x80000000 / -1 = 0x80000000 remainder 0 without a special path.
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [3:0]        i_op,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [DATA_W-1:0] o_hi,
    output logic [DATA_W-1:0] o_lo,
    output logic              o_div_by_zero
);

    logic                  w_signed;
    logic [2*DATA_W-1:0]   w_ext_a;
    logic [2*DATA_W-1:0]   w_ext_b;
    logic [2*DATA_W-1:0]   w_prod;
    logic                  w_a_neg;
    logic                  w_b_neg;
    logic [DATA_W-1:0]     w_a_mag;
    logic [DATA_W-1:0]     w_b_mag;
    logic [DATA_W-1:0]     w_b_safe;
    logic [DATA_W-1:0]     w_q_mag;
    logic [DATA_W-1:0]     w_r_mag;
    logic [DATA_W-1:0]     w_quot;
    logic [DATA_W-1:0]     w_rem;

    assign w_signed = (i_op == MDU_MULT) || (i_op == MDU_DIV);

    // One 64-bit multiplier: sign- or zero-extend, keep the low 64 bits.
    assign w_ext_a = {{DATA_W{w_signed & i_a[DATA_W-1]}}, i_a};
    assign w_ext_b = {{DATA_W{w_signed & i_b[DATA_W-1]}}, i_b};
    assign w_prod  = w_ext_a * w_ext_b;

    assign w_a_neg  = w_signed & i_a[DATA_W-1];
    assign w_b_neg  = w_signed & i_b[DATA_W-1];
    assign w_a_mag  = w_a_neg ? (~i_a + 1'b1) : i_a;
    assign w_b_mag  = w_b_neg ? (~i_b + 1'b1) : i_b;
    // Keep the divider defined for b==0; the result is discarded anyway.
    assign w_b_safe = (w_b_mag == '0) ? {{(DATA_W-1){1'b0}}, 1'b1} : w_b_mag;
    assign w_q_mag  = w_a_mag / w_b_safe;
    assign w_r_mag  = w_a_mag % w_b_safe;
    assign w_quot   = (w_a_neg ^ w_b_neg) ? (~w_q_mag + 1'b1) : w_q_mag;
    assign w_rem    = w_a_neg ? (~w_r_mag + 1'b1) : w_r_mag;

    assign o_div_by_zero = is_div_op(i_op) && (i_b == '0);

    // Select the HI/LO pair for the latched opcode.
    always_comb begin
        o_hi = '0;
        o_lo = '0;
        if ((i_op == MDU_MULT) || (i_op == MDU_MULTU)) begin
            o_hi = w_prod[2*DATA_W-1:DATA_W];
            o_lo = w_prod[DATA_W-1:0];
        end else if (is_div_op(i_op)) begin
            o_hi = w_rem;
            o_lo = w_quot;
        end
    end

endmodule

// File: rtl/e_mdu_sequencer.sv
// Execute-stage MDU sequencer: latches operands at start, counts a fixed
// latency, commits HI/LO on the last busy cycle and serves mf*/mt* ops.
module e_mdu_sequencer
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        E_MDUOp,
    input  logic [DATA_W-1:0] E_A,
    input  logic [DATA_W-1:0] E_B,
    input  logic              D_MDUUse,
    output logic              E_Start,
    output logic              E_Busy,
    output logic [DATA_W-1:0] E_MDUOut,
    output logic [DATA_W-1:0] E_HI,
    output logic [DATA_W-1:0] E_LO,
    output logic              MDU_Stall
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    logic [CNT_W-1:0]  r_cnt;
    logic [3:0]        r_op;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_hi;
    logic [DATA_W-1:0] r_lo;

    logic              w_busy;
    logic              w_start;
    logic              w_commit;
    logic [DATA_W-1:0] w_res_hi;
    logic [DATA_W-1:0] w_res_lo;
    logic              w_div_by_zero;

    // Result is computed from the latched operands, so E_A/E_B may change freely.
    mdu_arith u_arith (
        .i_op          (r_op),
        .i_a           (r_a),
        .i_b           (r_b),
        .o_hi          (w_res_hi),
        .o_lo          (w_res_lo),
        .o_div_by_zero (w_div_by_zero)
    );

    assign w_busy   = (r_cnt != '0);
    assign w_start  = is_start_op(E_MDUOp) && !w_busy;
    assign w_commit = (r_cnt == CNT_W'(1)) && !w_div_by_zero;

    assign E_Start   = w_start;
    assign E_Busy    = w_busy;
    assign E_HI      = r_hi;
    assign E_LO      = r_lo;
    assign MDU_Stall = D_MDUUse && (w_start || w_busy);

    // Move-from read port: HI/LO for mfhi/mflo, zero otherwise.
    always_comb begin
        E_MDUOut = '0;
        if (E_MDUOp == MDU_MFHI) begin
            E_MDUOut = r_hi;
        end else if (E_MDUOp == MDU_MFLO) begin
            E_MDUOut = r_lo;
        end
    end

    // Operand latches, latency counter and HI/LO update.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
            r_op  <= MDU_NONE;
            r_a   <= '0;
            r_b   <= '0;
            r_hi  <= '0;
            r_lo  <= '0;
        end else begin
            if (w_start) begin
                r_op  <= E_MDUOp;
                r_a   <= E_A;
                r_b   <= E_B;
                r_cnt <= is_div_op(E_MDUOp) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            end else if (w_busy) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end

            // Commit and moves cannot coincide: moves only act while idle.
            if (w_commit) begin
                r_hi <= w_res_hi;
                r_lo <= w_res_lo;
            end else if (!w_busy && (E_MDUOp == MDU_MTHI)) begin
                r_hi <= E_A;
            end else if (!w_busy && (E_MDUOp == MDU_MTLO)) begin
                r_lo <= E_A;
            end
        end
    end

endmodule

// File: tb/tb_e_mdu_sequencer.sv
// Scoreboard bench for e_mdu_sequencer: expected HI/LO pushed at start,
// popped and compared when the busy window closes.
module tb_e_mdu_sequencer;
    import mdu_pkg::*;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  E_MDUOp;
    logic [31:0] E_A;
    logic [31:0] E_B;
    logic        D_MDUUse;
    logic        E_Start;
    logic        E_Busy;
    logic [31:0] E_MDUOut;
    logic [31:0] E_HI;
    logic [31:0] E_LO;
    logic        MDU_Stall;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_hi;
    logic [31:0] model_lo;
    exp_t        sb_q[$];

    always #5 clk = ~clk;

    e_mdu_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .E_MDUOp   (E_MDUOp),
        .E_A       (E_A),
        .E_B       (E_B),
        .D_MDUUse  (D_MDUUse),
        .E_Start   (E_Start),
        .E_Busy    (E_Busy),
        .E_MDUOut  (E_MDUOut),
        .E_HI      (E_HI),
        .E_LO      (E_LO),
        .MDU_Stall (MDU_Stall)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model of HI/LO after a start op (64-bit arithmetic).
    task automatic model_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, sq, sr;
        longint unsigned up;
        case (op)
            MDU_MULT: begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                sq = sa * sb;
                model_hi = sq[63:32];
                model_lo = sq[31:0];
            end
            MDU_MULTU: begin
                up = {32'b0, a} * {32'b0, b};
                model_hi = up[63:32];
                model_lo = up[31:0];
            end
            MDU_DIV: if (b != 0) begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                sq = sa / sb;
                sr = sa % sb;
                model_hi = sr[31:0];
                model_lo = sq[31:0];
            end
            MDU_DIVU: if (b != 0) begin
                model_hi = a % b;
                model_lo = a / b;
            end
            default: ;
        endcase
    endtask

    // Launch one op in the current cycle and follow it to commit; returns in
    // cycle T+N+1 with the opcode back at NONE (ready for a back-to-back start).
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int n, input logic d_use);
        logic [3:0] garbage [4];
        exp_t       e;
        int         cnt;
        garbage[0] = MDU_MULT;
        garbage[1] = MDU_MTLO;
        garbage[2] = MDU_MTHI;
        garbage[3] = MDU_DIVU;
        E_MDUOp = op; E_A = a; E_B = b; D_MDUUse = d_use;
        #1;
        check("start", E_Start, 1);
        check("stall_start", MDU_Stall, d_use);
        model_op(op, a, b);
        e.hi = model_hi;
        e.lo = model_lo;
        sb_q.push_back(e);
        step();
        cnt = 0;
        while (E_Busy && cnt < 64) begin
            cnt++;
            E_MDUOp  = garbage[cnt % 4];
            E_A      = $urandom;
            E_B      = $urandom;
            D_MDUUse = 1'($urandom_range(0, 1));
            #1;
            check("start_blocked", E_Start, 0);
            check("stall_busy", MDU_Stall, D_MDUUse);
            step();
        end
        E_MDUOp = MDU_NONE; D_MDUUse = 1'b1;
        #1;
        check("busy_cycles", cnt, n);
        check("stall_done", MDU_Stall, 0);
        e = sb_q.pop_front();
        check("hi", E_HI, e.hi);
        check("lo", E_LO, e.lo);
        D_MDUUse = 1'b0;
        $display("op=%0d a=%08h b=%08h busy=%0d hi=%08h lo=%08h", op, a, b, cnt, E_HI, E_LO);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0]  rop [4];
        logic [31:0] ra, rb;
        reset = 1'b1; E_MDUOp = MDU_NONE; E_A = '0; E_B = '0; D_MDUUse = 1'b0;
        model_hi = '0; model_lo = '0;
        step(); step();
        check("rst_busy", E_Busy, 0);
        check("rst_hi", E_HI, 0);
        check("rst_lo", E_LO, 0);
        check("rst_out", E_MDUOut, 0);
        check("rst_stall", MDU_Stall, 0);
        reset = 1'b0;
        $display("reset done");

        // Directed arithmetic cases
        run_op(MDU_MULT, 32'hFFFFFFFE, 32'd3, 5, 1'b0);
        check("mult_hi_const", E_HI, 32'hFFFFFFFF);
        check("mult_lo_const", E_LO, 32'hFFFFFFFA);
        run_op(MDU_DIVU, 32'd100, 32'd7, 10, 1'b0);
        check("divu_lo_const", E_LO, 32'd14);
        check("divu_hi_const", E_HI, 32'd2);
        run_op(MDU_DIV, 32'hFFFFFFF9, 32'd2, 10, 1'b0);
        check("div_lo_const", E_LO, 32'hFFFFFFFD);
        check("div_hi_const", E_HI, 32'hFFFFFFFF);

        // Move-to, then divide by zero leaves HI/LO alone
        E_MDUOp = MDU_MTHI; E_A = 32'h1234; step();
        E_MDUOp = MDU_MTLO; E_A = 32'h5678; step();
        model_hi = 32'h1234; model_lo = 32'h5678;
        E_MDUOp = MDU_NONE; #1;
        check("mthi", E_HI, 32'h1234);
        check("mtlo", E_LO, 32'h5678);
        $display("mthi/mtlo hi=%08h lo=%08h", E_HI, E_LO);
        run_op(MDU_DIV, 32'h55, 32'd0, 10, 1'b1);
        E_MDUOp = MDU_MFLO; #1;
        check("mflo", E_MDUOut, 32'h5678);
        E_MDUOp = MDU_MFHI; #1;
        check("mfhi", E_MDUOut, 32'h1234);
        E_MDUOp = MDU_NONE; #1;
        check("none_out", E_MDUOut, 0);
        $display("mflo/mfhi read back");

        // Stall through the whole window, MTLO during busy ignored
        run_op(MDU_MULT, 32'd7, 32'd6, 5, 1'b1);
        check("stall_lo", E_LO, 32'd42);

        // Signed overflow divide
        run_op(MDU_DIV, 32'h80000000, 32'hFFFFFFFF, 10, 1'b0);
        check("ovf_lo", E_LO, 32'h80000000);
        check("ovf_hi", E_HI, 32'h0);

        // Back-to-back: MFHI and a new start in cycle T+N+1
        run_op(MDU_MULT, 32'h00012345, 32'hFFFF0001, 5, 1'b0);
        E_MDUOp = MDU_MFHI; #1;
        check("b2b_mfhi", E_MDUOut, model_hi);
        run_op(MDU_MULTU, 32'hDEADBEEF, 32'h00C0FFEE, 5, 1'b0);

        // Undefined opcode: no effect, zero output
        E_MDUOp = 4'hB; E_A = 32'hDEAD0000; #1;
        check("undef_out", E_MDUOut, 0);
        check("undef_start", E_Start, 0);
        step();
        E_MDUOp = MDU_NONE; #1;
        check("undef_hi", E_HI, model_hi);
        check("undef_lo", E_LO, model_lo);
        $display("undefined opcode ignored");

        // Random ops against the model
        rop[0] = MDU_MULT; rop[1] = MDU_MULTU; rop[2] = MDU_DIV; rop[3] = MDU_DIVU;
        for (int i = 0; i < 8; i++) begin
            logic [3:0] op;
            op = rop[i % 4];
            ra = $urandom;
            rb = (i >= 4) ? 32'($urandom_range(1, 300)) : $urandom;
            if (i == 6) rb = 32'hFFFFFFF3;
            run_op(op, ra, rb, is_div_op(op) ? 10 : 5, 1'($urandom_range(0, 1)));
        end

        // Reset during busy cycle 3 aborts the multiply
        E_MDUOp = MDU_MULTU; E_A = 32'hFFFFFFFF; E_B = 32'hFFFFFFFF; #1;
        check("abort_start", E_Start, 1);
        step();
        E_MDUOp = MDU_NONE;
        step(); step();
        check("abort_busy3", E_Busy, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        model_hi = '0; model_lo = '0;
        check("abort_busy", E_Busy, 0);
        check("abort_hi", E_HI, 0);
        check("abort_lo", E_LO, 0);
        for (int i = 0; i < 8; i++) step();
        check("abort_late_hi", E_HI, 0);
        check("abort_late_lo", E_LO, 0);
        check("abort_late_busy", E_Busy, 0);
        $display("reset abort hi=%08h lo=%08h", E_HI, E_LO);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
